timer_irq_peripheral: RTL

Memory-mapped peripheral block on the data bus of the pipelined MIPS CPU, occupying 0x4000_0000–0x4000_001F alongside data memory. Holds a reloadable 32-bit timer, LED/7-segment output registers, switch input, and a free-running system tick counter. Drives the `irqout` line that the main control unit samples as `IRQ` to flush IF and vector to the interrupt handler. The ISR clears the interrupt through TCON.

---
 rtl/timer_irq_peripheral_pkg.sv | 48 ++++
 rtl/timer_irq_peripheral_timer_counter.sv | 50 +++++
 rtl/timer_irq_peripheral.sv | 86 ++++++++
 3 files changed

// File: rtl/timer_irq_peripheral_pkg.sv
// rtl/timer_irq_peripheral_pkg.sv - register map, TCON bit indices and address decode for the timer peripheral
package timer_irq_peripheral_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

    localparam logic [4:0] TH_OFS      = 5'h00;
    localparam logic [4:0] TL_OFS      = 5'h04;
    localparam logic [4:0] TCON_OFS    = 5'h08;
    localparam logic [4:0] LED_OFS     = 5'h0C;
    localparam logic [4:0] SWITCH_OFS  = 5'h10;
    localparam logic [4:0] DIGI_OFS    = 5'h14;
    localparam logic [4:0] SYSTICK_OFS = 5'h18;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IP = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LED,
        SEL_SWITCH,
        SEL_DIGI,
        SEL_SYSTICK
    } reg_sel_e;

    // Offset is taken relative to the base so the window needs no alignment assumption.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] ofs;
        ofs = addr - base;
        decode_addr = SEL_NONE;
        if (ofs[31:5] == 27'd0) begin
            case (ofs[4:0])
                TH_OFS:      decode_addr = SEL_TH;
                TL_OFS:      decode_addr = SEL_TL;
                TCON_OFS:    decode_addr = SEL_TCON;
                LED_OFS:     decode_addr = SEL_LED;
                SWITCH_OFS:  decode_addr = SEL_SWITCH;
                DIGI_OFS:    decode_addr = SEL_DIGI;
                SYSTICK_OFS: decode_addr = SEL_SYSTICK;
                default:     decode_addr = SEL_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/timer_irq_peripheral_timer_counter.sv
// rtl/timer_irq_peripheral_timer_counter.sv - reloadable 32-bit timer with TCON control and interrupt pending
module timer_counter
    import timer_irq_peripheral_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        th_we,
    input  logic        tl_we,
    input  logic        tcon_we,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irqout
);

    logic overflow;

    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

    // Bus writes take priority over the counter; reload always sees the pre-write TH.
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= 32'd0;
            tl   <= 32'd0;
            tcon <= 3'd0;
        end else begin
            if (th_we) begin
                th <= wdata;
            end

            if (tl_we) begin
                tl <= wdata;
            end else if (overflow) begin
                tl <= th;
            end else if (tcon[TCON_EN]) begin
                tl <= tl + 32'd1;
            end

            if (tcon_we) begin
                tcon <= wdata[2:0];
            end else if (overflow && tcon[TCON_IE]) begin
                tcon[TCON_IP] <= 1'b1;
            end
        end
    end

    assign irqout = tcon[TCON_IE] & tcon[TCON_IP];

endmodule

// File: rtl/timer_irq_peripheral.sv
// rtl/timer_irq_peripheral.sv - memory-mapped timer, LED/7-seg, switch and systick block driving the CPU interrupt line
module timer_irq_peripheral
    import timer_irq_peripheral_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    reg_sel_e    sel;
    logic        th_we;
    logic        tl_we;
    logic        tcon_we;
    logic        led_we;
    logic        digi_we;
    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [31:0] systick;

    always_comb begin
        sel     = decode_addr(addr, BASE_ADDR);
        th_we   = wr && (sel == SEL_TH);
        tl_we   = wr && (sel == SEL_TL);
        tcon_we = wr && (sel == SEL_TCON);
        led_we  = wr && (sel == SEL_LED);
        digi_we = wr && (sel == SEL_DIGI);
    end

    timer_counter u_timer_counter (
        .clk     (clk),
        .reset   (reset),
        .th_we   (th_we),
        .tl_we   (tl_we),
        .tcon_we (tcon_we),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irqout  (irqout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= 8'd0;
            digi    <= 12'd0;
            systick <= 32'd0;
        end else begin
            if (led_we) begin
                led <= wdata[7:0];
            end
            if (digi_we) begin
                digi <= wdata[11:0];
            end
            systick <= systick + 32'd1;
        end
    end

    // Purely combinational, so a simultaneous read+write returns the pre-write value.
    always_comb begin
        rdata = 32'd0;
        if (rd) begin
            case (sel)
                SEL_TH:      rdata = th;
                SEL_TL:      rdata = tl;
                SEL_TCON:    rdata = {29'd0, tcon};
                SEL_LED:     rdata = {24'd0, led};
                SEL_SWITCH:  rdata = {24'd0, switch};
                SEL_DIGI:    rdata = {20'd0, digi};
                SEL_SYSTICK: rdata = systick;
                default:     rdata = 32'd0;
            endcase
        end
    end

endmodule
